// File: rtl/timer_irq_ctrl.sv
// rtl/timer_irq_ctrl.sv - sticky W1C timer status, masked level IRQ with minimum low-time holdoff.
// Optional missed-event counters are built when TIMER_IRQ_MISS_CNT_EN is defined.
module timer_irq_ctrl #(
  parameter int HOLDOFF_CYCLES = 4,
  parameter int MISS_W         = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cnt0_done,
  input  logic              i_cnt1_done,
  input  logic [1:0]        i_irq_en,
  input  logic              i_clr_valid,
  input  logic [1:0]        i_clr_mask,
  input  logic              i_miss_clr,
  output logic [1:0]        o_status,
  output logic [1:0]        o_pending,
  output logic              o_irq,
  output logic [MISS_W-1:0] o_miss_cnt0,
  output logic [MISS_W-1:0] o_miss_cnt1
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LOAD = (HOLDOFF_CYCLES > 0) ? 8'(HOLDOFF_CYCLES - 1) : 8'd0;

  state_t     state;
  logic [7:0] hold_cnt;
  logic       irq_q;
  logic [1:0] status_q;
  logic [1:0] done;
  logic [1:0] clr_bits;

  assign done     = {i_cnt1_done, i_cnt0_done};
  assign clr_bits = i_clr_valid ? i_clr_mask : 2'b00;

  // OR-ing the set term after the clear makes a simultaneous set win.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q <= 2'b00;
    end else begin
      status_q <= (status_q & ~clr_bits) | done;
    end
  end

  assign o_status  = status_q;
  assign o_pending = status_q & i_irq_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= 8'd0;
      irq_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|o_pending) begin
            state <= ACTIVE;
            irq_q <= 1'b1;
          end
        end
        ACTIVE: begin
          if (o_pending == 2'b00) begin
            irq_q <= 1'b0;
            if (HOLDOFF_CYCLES > 0) begin
              state    <= HOLDOFF;
              hold_cnt <= HOLD_LOAD;
            end else begin
              state <= IDLE;
            end
          end
        end
        HOLDOFF: begin
          // The count runs HOLD_LOAD..0, giving exactly HOLDOFF_CYCLES low cycles.
          if (hold_cnt == 8'd0) begin
            if (|o_pending) begin
              state <= ACTIVE;
              irq_q <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          irq_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_irq = irq_q;

`ifdef TIMER_IRQ_MISS_CNT_EN
  localparam logic [MISS_W-1:0] MISS_MAX = '1;

  logic [MISS_W-1:0] miss0_q;
  logic [MISS_W-1:0] miss1_q;
  logic [1:0]        miss_inc;

  // An event is lost only if its bit is already set and not being cleared now.
  assign miss_inc = done & status_q & ~clr_bits;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss0_q <= '0;
      miss1_q <= '0;
    end else if (i_miss_clr) begin
      miss0_q <= '0;
      miss1_q <= '0;
    end else begin
      if (miss_inc[0] && (miss0_q != MISS_MAX)) miss0_q <= miss0_q + 1'b1;
      if (miss_inc[1] && (miss1_q != MISS_MAX)) miss1_q <= miss1_q + 1'b1;
    end
  end

  assign o_miss_cnt0 = miss0_q;
  assign o_miss_cnt1 = miss1_q;
`else
  logic unused_miss_clr;

  assign unused_miss_clr = i_miss_clr;
  assign o_miss_cnt0     = '0;
  assign o_miss_cnt1     = '0;
`endif

endmodule
